mac_instr_sequencer: RTL and testbench
======================================

# mac_instr_sequencer

Program buffer and playback engine directly upstream of the MAC core. Captures a short program of 8-bit MAC instruction bytes, then on command streams them to the MAC's instruction input one per accepted cycle over a valid/ready handshake. This replaces hand-driven per-cycle byte stimulus with a deterministic, stallable instruction source.

## Interface
- `DEPTH`, 16: program buffer entries (power of two, 4..64).
- `AW`, $clog2(DEPTH): pointer width (derived; do not override).
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_valid` in 1: program byte offered.
- `wr_data` in 8: program byte; [7:6] opcode (00 NOP/HALT, 01 LOAD_A, 10 LOAD_B, 11 MAC), [5:0] operand.
- `wr_ready` out 1: byte accepted this cycle when `wr_valid && wr_ready`.
- `clear` in 1: empty the program buffer (IDLE only).
- `start` in 1: begin playback (IDLE only).
- `abort` in 1: terminate playback (RUN only).
- `loop_cnt` in 4: extra replays; used only with `MAC_SEQ_LOOP_EN`.
- `instr_valid` out 1: `instr_data` holds an instruction for the MAC.
- `instr_data` out 8: instruction byte to the MAC.
- `instr_ready` in 1: MAC consumes the byte this cycle.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on normal completion.
- `prog_len` out AW+1: number of stored bytes.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, `prog_len`=0, read pointer 0, all outputs 0 (`wr_ready` becomes 1 the cycle after reset is released).
- IDLE: `wr_ready = !start && !clear && prog_len != DEPTH`. An accepted byte is stored at index `prog_len` and `prog_len` increments. `clear` sets `prog_len`=0. `start` has priority over `clear`, and `clear` over writes; a write offered with `start` or `clear` is not accepted.
- Full: when `prog_len == DEPTH`, `wr_ready`=0 and the buffer is unchanged.
- Start in IDLE: read pointer ← 0.
  - If `prog_len`=0 or entry 0 is 0x00, go to DONE.
  - Otherwise go to RUN, presenting entry 0.
- RUN: `instr_valid`=1, and `instr_data` = entry[ptr] (registered). Data is held stable while `instr_valid && !instr_ready`.
- On accept: ptr+1. If ptr+1 == `prog_len`, or entry[ptr+1] == 0x00 (HALT), the playback pass ends. HALT is never forwarded.
- End of pass: go to DONE (or replay; see Configuration). `instr_valid` drops in the same cycle the state leaves RUN.
- DONE: lasts one cycle with `done`=1, then returns to IDLE. The buffer contents and `prog_len` are kept, so `start` can replay the program.
- `abort` in RUN: go to IDLE next cycle, `instr_valid`=0, no `done` pulse. If `abort` and an accept occur together, the accepted byte counts as consumed and is not re-sent.
- `start`, `clear` and writes are ignored outside IDLE. `abort` is ignored outside RUN.
- Synchronous `rst` mid-RUN: next cycle is IDLE, `instr_valid`=0, `prog_len`=0.

## Timing
- `start` sampled in cycle N. In cycle N+1 `instr_valid`=1 with entry 0.
- Throughput: 1 instruction/cycle while `instr_ready`=1. There is no bubble between entries.
- Last accept in cycle M: `done`=1 in M+1, and `busy`=0 from M+1.
- Empty or HALT-first program: `done`=1 in N+1, and `instr_valid` never rises.
- Write accepted in cycle N: `prog_len` updates in N+1.

## Configuration
- `MAC_SEQ_LOOP_EN` defined:
  - `loop_cnt` is sampled at `start`, and the program plays `loop_cnt`+1 times back-to-back.
  - The pointer wraps to 0 with no idle cycle between passes.
  - `done` pulses once, after the final pass.
  - `abort` ends all remaining passes.
- `MAC_SEQ_LOOP_EN` undefined: `loop_cnt` is ignored (port still present) and the program plays exactly once.

## Structure
- Package `mac_seq_pkg` holds:
  - opcode enum (NOP, LOAD_A, LOAD_B, MAC);
  - the `HALT_BYTE` = 8'h00 constant;
  - the state enum (IDLE, RUN, DONE).
- Sub-module `mac_seq_buffer` is the DEPTH×8 register array with write index, `prog_len` counter and asynchronous read port. The top level holds the FSM, read pointer, output register and loop counter.

## Test plan
- Load 41,42,81,82,C0,44,83,C0,00, then `start` with `instr_ready`=1:
  - `prog_len`=9;
  - outputs 41,42,81,82,C0,44,83,C0 on 8 consecutive cycles starting at N+1;
  - `done` at N+9, and 00 is never presented.
- Same program, `instr_ready` low for 3 cycles while 81 is presented: 81 is held stable for those cycles, and all 8 bytes are delivered with none dropped or duplicated.
- Write 16 bytes of 0xC1, then offer a 17th: `wr_ready`=0, `prog_len`=16, and playback emits 16×C1.
- `start` with `prog_len`=0: `done` at N+1, `instr_valid` stays 0. Then `clear` after a load gives `prog_len`=0.
- `abort` after the 3rd accept (81): next cycle IDLE, `instr_valid`=0, no `done`. Assert `rst` mid-RUN in a separate run: `prog_len`=0 and outputs are 0.
- With `MAC_SEQ_LOOP_EN`, program 41,C0 and `loop_cnt`=2: output is 41,C0,41,C0,41,C0 contiguously, followed by a single `done`.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC instruction sequencer.
package mac_seq_pkg;

  // Instruction opcode carried in bits [7:6] of each program byte
  typedef enum logic [1:0] {
    NOP    = 2'b00,
    LOAD_A = 2'b01,
    LOAD_B = 2'b10,
    MAC    = 2'b11
  } opcode_e;

  // An all-zero byte terminates a playback pass and is never forwarded
  localparam logic [7:0] HALT_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mac_seq_buffer.sv
// Program buffer: DEPTH x 8 register array, append-only write index
// (equal to prog_len), and two asynchronous read ports (entry 0 and a
// selectable entry).
module mac_seq_buffer
  import mac_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    head_data,
  output logic [AW:0]   prog_len
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW:0] len_q;
  logic [AW:0] len_d;

  // Next contents: clear wins over append; caller guarantees no write when full
  always_comb begin
    mem_d = mem_q;
    len_d = len_q;
    if (clr) begin
      len_d = '0;
    end else if (wr_en) begin
      mem_d[len_q[AW-1:0]] = wr_data;
      len_d                = len_q + (AW+1)'(1);
    end
  end

  // Storage and length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
      mem_q <= mem_d;
    end
  end

  assign rd_data   = mem_q[rd_addr];
  assign head_data = mem_q[0];
  assign prog_len  = len_q;

endmodule

// File: rtl/mac_instr_sequencer.sv
// MAC instruction sequencer: captures a program of instruction bytes and
// streams them to the MAC over valid/ready. Optional feature macro
// MAC_SEQ_LOOP_EN replays the program loop_cnt+1 times back-to-back.
module mac_instr_sequencer
  import mac_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        clear,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  loop_cnt,
  output logic        instr_valid,
  output logic [7:0]  instr_data,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic [AW:0] prog_len
);

  state_e      state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [3:0]  loops_q, loops_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [AW:0]   nxt_ptr_c;
  logic [AW-1:0] rd_addr_c;
  logic [7:0]    rd_data_c;
  logic [7:0]    head_c;
  logic [AW:0]   prog_len_c;
  logic          end_pass_c;
  logic          wr_ready_c;
  logic          buf_wr_en_c;
  logic          buf_clr_c;
  logic [3:0]    loop_init_c;

`ifdef MAC_SEQ_LOOP_EN
  assign loop_init_c = loop_cnt;
`else
  logic unused_loop_c;
  assign loop_init_c   = 4'd0;
  assign unused_loop_c = ^loop_cnt;
`endif

  mac_seq_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_en_c),
    .wr_data  (wr_data),
    .clr      (buf_clr_c),
    .rd_addr  (rd_addr_c),
    .rd_data  (rd_data_c),
    .head_data(head_c),
    .prog_len (prog_len_c)
  );

  // Next-state, lookahead read and buffer control
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    loops_d     = loops_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    buf_wr_en_c = 1'b0;
    buf_clr_c   = 1'b0;
    nxt_ptr_c   = ptr_q + (AW+1)'(1);
    rd_addr_c   = nxt_ptr_c[AW-1:0];
    end_pass_c  = (nxt_ptr_c == prog_len_c) || (rd_data_c == HALT_BYTE);
    wr_ready_c  = !rst && (state_q == IDLE) && !start && !clear &&
                  (prog_len_c != (AW+1)'(DEPTH));
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = '0;
          loops_d = loop_init_c;
          if ((prog_len_c == '0) || (head_c == HALT_BYTE)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            data_d  = head_c;
          end
        end else if (clear) begin
          buf_clr_c = 1'b1;
        end else begin
          buf_wr_en_c = wr_valid && wr_ready_c;
        end
      end
      RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (instr_ready) begin
          if (!end_pass_c) begin
            ptr_d  = nxt_ptr_c;
            data_d = rd_data_c;
          end else if (loops_q != 4'd0) begin
            loops_d = loops_q - 4'd1;
            ptr_d   = '0;
            data_d  = head_c;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, loop counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      loops_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      loops_q <= loops_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_ready    = wr_ready_c;
  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prog_len    = prog_len_c;

endmodule

// File: tb/tb_mac_instr_sequencer.sv
// Directed bench for mac_instr_sequencer (DEPTH=16).
module tb_mac_instr_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, clear, start, abort;
  logic [7:0]  wr_data, instr_data;
  logic [3:0]  loop_cnt;
  logic        instr_valid, instr_ready, busy, done;
  logic [AW:0] prog_len;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prog9[$];
  logic [7:0] exp8[$];
  logic [7:0] full16[$];
  logic [7:0] prog2[$];
  logic [7:0] exp_loop[$];
  logic [7:0] none[$];

  mac_instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .clear      (clear),
    .start      (start),
    .abort      (abort),
    .loop_cnt   (loop_cnt),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_ready(instr_ready),
    .busy       (busy),
    .done       (done),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b[$]);
    foreach (b[i]) begin
      wr_valid = 1'b1;
      wr_data  = b[i];
      #1;
      chk("load_wr_ready", 32'(wr_ready), 32'd1);
      step();
    end
    wr_valid = 1'b0;
  endtask

  // Start playback, optionally stall on accept index stall_idx, and compare stream
  task automatic run_prog(input string tag, input logic [7:0] e[$],
                          input int stall_idx, input int stall_len);
    int got      = 0;
    int stalled  = 0;
    int done_cyc = -1;
    start       = 1'b1;
    instr_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_valid_at_done"}, 32'(instr_valid), 32'd0);
      end else if (instr_valid) begin
        if (got >= e.size()) begin
          chk({tag, "_extra_byte"}, 32'(got), 32'(e.size()));
        end else begin
          chk({tag, "_data"}, 32'(instr_data), 32'(e[got]));
        end
        if (got == stall_idx && stalled < stall_len) begin
          instr_ready = 1'b0;
          stalled++;
        end else begin
          instr_ready = 1'b1;
          got++;
        end
      end
      step();
    end
    chk({tag, "_count"}, 32'(got), 32'(e.size()));
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(e.size() + stall_len));
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    prog9    = '{8'h41, 8'h42, 8'h81, 8'h82, 8'hC0, 8'h44, 8'h83, 8'hC0, 8'h00};
    exp8     = '{8'h41, 8'h42, 8'h81, 8'h82, 8'hC0, 8'h44, 8'h83, 8'hC0};
    prog2    = '{8'h41, 8'hC0};
`ifdef MAC_SEQ_LOOP_EN
    exp_loop = '{8'h41, 8'hC0, 8'h41, 8'hC0, 8'h41, 8'hC0};
`else
    exp_loop = '{8'h41, 8'hC0};
`endif
    for (int i = 0; i < 16; i++) full16.push_back(8'hC1);

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
    abort = 1'b0; loop_cnt = '0; instr_ready = 1'b0;
    step();
    step();
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Basic program with trailing HALT
    load(prog9);
    chk("basic_prog_len", 32'(prog_len), 32'd9);
    run_prog("basic", exp8, -1, 0);

    // Stall three cycles while 81 is presented
    run_prog("stall", exp8, 2, 3);

    // Abort after the third accept
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_pre_data", 32'(instr_data), 32'h82);
    abort = 1'b1; instr_ready = 1'b0;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("abort_done_late", 32'(done), 32'd0);
    chk("abort_prog_len", 32'(prog_len), 32'd9);
    run_prog("replay", exp8, -1, 0);

    // Reset in the middle of playback
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_prog_len", 32'(prog_len), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(instr_data), 32'd0);

    // Empty program
    run_prog("empty", none, -1, 0);

    // Clear after a load; the write offered with clear is refused
    load(prog2);
    chk("clr_pre_len", 32'(prog_len), 32'd2);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
    #1;
    chk("clr_wr_ready", 32'(wr_ready), 32'd0);
    step();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clr_prog_len", 32'(prog_len), 32'd0);

    // Fill to DEPTH, then the 17th byte is refused
    load(full16);
    wr_valid = 1'b1; wr_data = 8'hC1;
    #1;
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    step();
    wr_valid = 1'b0;
    chk("full_prog_len", 32'(prog_len), 32'd16);
    run_prog("full", full16, -1, 0);

    // Loop replay (single pass when the feature is compiled out)
    clear = 1'b1;
    step();
    clear = 1'b0;
    load(prog2);
    loop_cnt = 4'd2;
    run_prog("loop", exp_loop, -1, 0);
    loop_cnt = 4'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
